// File: rtl/stepper_cmd_sequencer.sv
// Single-axis stepper sequencer: decodes UART command bytes, runs an enable lead
// and a fixed-rate step train to a pulse target, and returns one ack byte per event.
module stepper_cmd_sequencer #(
  parameter int HALF_PERIOD = 25000,
  parameter int ENABLE_LEAD = 1000,
  parameter int TGT_W       = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_data_en,
  input  logic       limit_n,
  output logic       step,
  output logic       dir,
  output logic       enable_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] ack_data,
  output logic       ack_en
);

  localparam int CNT_MAX = (HALF_PERIOD > ENABLE_LEAD) ? HALF_PERIOD : ENABLE_LEAD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HP_LAST   = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(ENABLE_LEAD - 1);

  localparam logic [7:0] CH_A     = "A";
  localparam logic [7:0] CH_H     = "H";
  localparam logic [7:0] CH_N     = "N";
  localparam logic [7:0] CH_R     = "R";
  localparam logic [7:0] CH_GO    = "3";
  localparam logic [7:0] CH_ABORT = "4";
  localparam logic [7:0] CH_ERR   = "?";
  localparam logic [7:0] CH_DONE  = "K";
  localparam logic [7:0] CH_LIM   = "!";

  typedef enum logic [1:0] {IDLE, LEAD, STEP_HI, STEP_LO} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [TGT_W-1:0]   target, target_nxt;
  logic [TGT_W-1:0]   pulse_cnt, pulse_cnt_nxt;
  logic               dir_cfg, dir_cfg_nxt, dir_nxt;
  logic               done_nxt;
  logic               lim_sync_p0, lim_sync_p1, lim;
  logic               is_idle, start, abort;
  logic               cmd_vld, evt_vld;
  logic [7:0]         cmd_byte, evt_byte;
  logic               pend_vld, pend_vld_nxt;
  logic [7:0]         pend_byte, pend_byte_nxt;
  logic               ack_en_nxt;
  logic [7:0]         ack_data_nxt;

  assign lim      = ~lim_sync_p1;
  assign is_idle  = (state == IDLE);
  assign step     = (state == STEP_HI);
  assign enable_n = is_idle;
  assign busy     = ~is_idle;

  // Command decode, FSM next state and ack arbitration
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = is_idle ? '0 : cnt + CNT_W'(1);
    target_nxt    = target;
    pulse_cnt_nxt = pulse_cnt;
    dir_cfg_nxt   = dir_cfg;
    dir_nxt       = dir;
    done_nxt      = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    cmd_vld       = 1'b0;
    cmd_byte      = CH_ERR;
    evt_vld       = 1'b0;
    evt_byte      = CH_DONE;

    if (rx_data_en) begin
      cmd_vld = 1'b1;
      if (rx_data inside {[CH_A:CH_H]}) begin
        if (is_idle) begin
          target_nxt = TGT_W'(rx_data - CH_A + 8'd1) << 9;
          cmd_byte   = rx_data;
        end
      end else if (rx_data == CH_N || rx_data == CH_R) begin
        if (is_idle) begin
          dir_cfg_nxt = (rx_data == CH_N);
          cmd_byte    = rx_data;
        end
      end else if (rx_data == CH_GO) begin
        if (is_idle && !lim) begin
          start    = 1'b1;
          cmd_byte = CH_GO;
        end
      end else if (rx_data == CH_ABORT) begin
        abort    = 1'b1;
        cmd_byte = CH_ABORT;
      end
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = LEAD;
          cnt_nxt       = '0;
          pulse_cnt_nxt = '0;
          dir_nxt       = dir_cfg;
        end
      end
      LEAD: begin
        if (cnt == LEAD_LAST) begin
          state_nxt = STEP_HI;
          cnt_nxt   = '0;
        end
      end
      STEP_HI: begin
        if (cnt == HP_LAST) begin
          state_nxt     = STEP_LO;
          cnt_nxt       = '0;
          pulse_cnt_nxt = pulse_cnt + TGT_W'(1);
        end
      end
      STEP_LO: begin
        if (cnt == HP_LAST) begin
          cnt_nxt = '0;
          if (pulse_cnt == target) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            evt_vld   = 1'b1;
            evt_byte  = CH_DONE;
          end else begin
            state_nxt = STEP_HI;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Abort beats limit, limit beats normal completion
    if (!is_idle && lim) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      done_nxt  = 1'b0;
      evt_vld   = 1'b1;
      evt_byte  = CH_LIM;
    end
    if (!is_idle && abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      done_nxt  = 1'b0;
      evt_vld   = 1'b0;
    end

    ack_en_nxt    = 1'b0;
    ack_data_nxt  = ack_data;
    pend_vld_nxt  = pend_vld;
    pend_byte_nxt = pend_byte;
    if (cmd_vld) begin
      ack_en_nxt   = 1'b1;
      ack_data_nxt = cmd_byte;
      if (evt_vld) begin
        pend_vld_nxt  = 1'b1;
        pend_byte_nxt = evt_byte;
      end
    end else if (pend_vld) begin
      ack_en_nxt    = 1'b1;
      ack_data_nxt  = pend_byte;
      pend_vld_nxt  = evt_vld;
      pend_byte_nxt = evt_byte;
    end else if (evt_vld) begin
      ack_en_nxt   = 1'b1;
      ack_data_nxt = evt_byte;
    end
  end

  // State and output registers; limit synchronizer idles in the released level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      target      <= TGT_W'(512);
      pulse_cnt   <= '0;
      dir_cfg     <= 1'b0;
      dir         <= 1'b0;
      done        <= 1'b0;
      ack_en      <= 1'b0;
      ack_data    <= '0;
      pend_vld    <= 1'b0;
      pend_byte   <= '0;
      lim_sync_p0 <= 1'b1;
      lim_sync_p1 <= 1'b1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      target      <= target_nxt;
      pulse_cnt   <= pulse_cnt_nxt;
      dir_cfg     <= dir_cfg_nxt;
      dir         <= dir_nxt;
      done        <= done_nxt;
      ack_en      <= ack_en_nxt;
      ack_data    <= ack_data_nxt;
      pend_vld    <= pend_vld_nxt;
      pend_byte   <= pend_byte_nxt;
      lim_sync_p0 <= limit_n;
      lim_sync_p1 <= lim_sync_p0;
    end
  end

endmodule

// File: tb/tb_stepper_cmd_sequencer.sv
// Bench for stepper_cmd_sequencer: directed scenarios plus random command traffic,
// compared every cycle against a timing model derived from the run start time.
module tb_stepper_cmd_sequencer;

  localparam int HP = 4;
  localparam int LD = 2;
  localparam int TW = 13;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_en = 1'b0;
  logic       limit_n = 1'b1;
  logic       step, dir, enable_n, busy, done, ack_en;
  logic [7:0] ack_data;

  int checks = 0;
  int failures = 0;

  stepper_cmd_sequencer #(.HALF_PERIOD(HP), .ENABLE_LEAD(LD), .TGT_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_en(rx_data_en),
    .limit_n(limit_n), .step(step), .dir(dir), .enable_n(enable_n), .busy(busy),
    .done(done), .ack_data(ack_data), .ack_en(ack_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: run timing is computed from the edge at which the start was accepted
  int unsigned n_edge = 0, m_s = 0, m_target = 512, m_last_pulses = 0;
  bit          m_active = 0, m_dircfg = 0, m_dir = 0, m_pend_v = 0;
  logic [7:0]  m_pend = 8'h00;
  logic [1:0]  m_lim_hist = 2'b11;
  logic        exp_step = 0, exp_en_n = 1, exp_busy = 0, exp_done = 0, exp_ack_en = 0;
  logic [7:0]  exp_ack_data = 8'h00;

  always @(posedge clk or negedge rst_n) begin : model
    bit lim, start, stop, evt_v, cmd_v, done_now;
    logic [7:0] evt_b, cmd_b;
    int unsigned e;
    if (!rst_n) begin
      n_edge = 0; m_s = 0; m_target = 512; m_active = 0; m_dircfg = 0; m_dir = 0;
      m_pend_v = 0; m_lim_hist = 2'b11;
      exp_step = 0; exp_en_n = 1; exp_busy = 0; exp_done = 0; exp_ack_en = 0; exp_ack_data = 0;
    end else begin
      lim = !m_lim_hist[1];
      m_lim_hist = {m_lim_hist[0], limit_n};
      n_edge++;
      e = n_edge - m_s;
      start = 0; stop = 0; evt_v = 0; evt_b = 0; cmd_v = 0; cmd_b = "?"; done_now = 0;
      if (m_active) begin
        if (rx_data_en && rx_data == "4") stop = 1;
        else if (lim) begin stop = 1; evt_v = 1; evt_b = "!"; end
        else if (e == LD + 2 * HP * m_target) begin
          stop = 1; evt_v = 1; evt_b = "K"; done_now = 1;
        end
        if (stop) m_last_pulses = (e >= LD + 1) ? (e - 1 - LD) / (2 * HP) + 1 : 0;
      end
      if (rx_data_en) begin
        cmd_v = 1;
        if (rx_data inside {["A":"H"]}) begin
          if (!m_active) begin m_target = (int'(rx_data) - 64) * 512; cmd_b = rx_data; end
        end else if (rx_data == "N" || rx_data == "R") begin
          if (!m_active) begin m_dircfg = (rx_data == "N"); cmd_b = rx_data; end
        end else if (rx_data == "3") begin
          if (!m_active && !lim) begin start = 1; cmd_b = "3"; end
        end else if (rx_data == "4") cmd_b = "4";
      end
      if (stop) m_active = 0;
      if (start) begin m_active = 1; m_s = n_edge; m_dir = m_dircfg; end
      exp_ack_en = 0;
      if (cmd_v) begin
        exp_ack_en = 1; exp_ack_data = cmd_b;
        if (evt_v) begin m_pend_v = 1; m_pend = evt_b; end
      end else if (m_pend_v) begin
        exp_ack_en = 1; exp_ack_data = m_pend; m_pend_v = evt_v; m_pend = evt_b;
      end else if (evt_v) begin
        exp_ack_en = 1; exp_ack_data = evt_b;
      end
      exp_done = done_now;
      exp_busy = m_active;
      exp_en_n = !m_active;
      e = n_edge - m_s;
      exp_step = m_active && (e >= LD) && (((e - LD) % (2 * HP)) < HP);
    end
  end

  bit          chk_on = 0;
  int unsigned obs_rises = 0;
  logic        prev_step = 0;

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      check("step", 32'(step), 32'(exp_step));
      check("enable_n", 32'(enable_n), 32'(exp_en_n));
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      check("dir", 32'(dir), 32'(m_dir));
      check("ack_en", 32'(ack_en), 32'(exp_ack_en));
      if (exp_ack_en) check("ack_data", 32'(ack_data), 32'(exp_ack_data));
      if (step && !prev_step) obs_rises++;
      prev_step = step;
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_data_en = 1'b1;
    @(negedge clk);
    rx_data_en = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget, input int unsigned base, input string tag);
    int unsigned c = 0;
    while (busy && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_timeout"}, 32'(busy), 32'd0);
    check({tag, "_pulses"}, obs_rises - base, m_last_pulses);
  endtask

  initial begin
    int unsigned base, c;
    int unsigned op;
    repeat (2) @(negedge clk);
    #1;
    check("rst_step", 32'(step), 0);
    check("rst_enable_n", 32'(enable_n), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ack_en", 32'(ack_en), 0);
    check("rst_ack_data", 32'(ack_data), 0);
    check("rst_dir", 32'(dir), 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1;
    @(negedge clk);

    // Reset mid-run returns to defaults immediately
    send("C"); send("N");
    send("3");
    c = 0;
    while (!step && c < 50) begin @(negedge clk); c++; end
    check("t1_step_seen", 32'(step), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_step", 32'(step), 0);
    check("t1_enable_n", 32'(enable_n), 1);
    check("t1_busy", 32'(busy), 0);
    check("t1_dir", 32'(dir), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = obs_rises;
    send("3");
    wait_idle(6000, base, "t1_run");
    check("t1_target512", obs_rises - base, 512);

    // Plain 'A' run
    send("A");
    base = obs_rises;
    send("3");
    wait_idle(6000, base, "t2_run");
    check("t2_pulses", obs_rises - base, 512);

    // Abort after 10 pulses
    send("B");
    base = obs_rises;
    send("3");
    c = 0;
    while (obs_rises - base < 10 && c < 500) begin @(negedge clk); c++; end
    check("t3_reach10", 32'(obs_rises - base >= 10), 1);
    repeat (4) @(negedge clk);
    send("4");
    check("t3_step", 32'(step), 0);
    check("t3_enable_n", 32'(enable_n), 1);
    check("t3_ack", 32'(ack_data), "4");
    check("t3_done", 32'(done), 0);
    wait_idle(10, base, "t3_run");
    check("t3_pulses10", obs_rises - base, 10);

    // Limit stop, then start refused while limit held
    send("A");
    base = obs_rises;
    send("3");
    repeat ($urandom_range(3, 40)) @(negedge clk);
    limit_n = 1'b0;
    c = 0;
    while (busy && c < 10) begin @(negedge clk); c++; end
    check("t4_lim_latency_le3", 32'(c <= 3), 1);
    wait_idle(10, base, "t4_run");
    repeat (2) @(negedge clk);
    send("3");
    check("t4_start_refused_ack", 32'(ack_data), "?");
    check("t4_start_refused_busy", 32'(busy), 0);
    limit_n = 1'b1;
    repeat (3) @(negedge clk);

    // Configuration commands refused while running
    send("A"); send("N");
    base = obs_rises;
    send("3");
    repeat (20) @(negedge clk);
    send("R");
    check("t5_R_refused", 32'(ack_data), "?");
    check("t5_dir_held", 32'(dir), 1);
    send("C");
    check("t5_C_refused", 32'(ack_data), "?");
    wait_idle(6000, base, "t5_run");
    check("t5_target_kept", obs_rises - base, 512);
    send("R");
    base = obs_rises;
    send("3");
    repeat (60) @(negedge clk);
    check("t5_dir0", 32'(dir), 0);
    send("4");
    wait_idle(10, base, "t5_run2");

    // Command byte in the completion cycle: '?' first, 'K' next
    send("A");
    base = obs_rises;
    send("3");
    repeat (LD + 2 * HP * 512 - 1) @(negedge clk);
    send("x");
    check("t6_ack_q_en", 32'(ack_en), 1);
    check("t6_ack_q", 32'(ack_data), "?");
    check("t6_done", 32'(done), 1);
    @(negedge clk);
    check("t6_ack_k_en", 32'(ack_en), 1);
    check("t6_ack_k", 32'(ack_data), "K");
    check("t6_pulses", obs_rises - base, 512);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1: send(busy ? 8'(8'h43 + $urandom_range(0, 5)) : 8'(8'h41 + $urandom_range(0, 1)));
        2: send($urandom_range(0, 1) ? 8'h4E : 8'h52);
        3, 4: send("3");
        5: send("4");
        6: send(8'($urandom_range(0, 255)));
        7: begin
          limit_n = 1'b0;
          repeat ($urandom_range(1, 6)) @(negedge clk);
          limit_n = 1'b1;
        end
        default: repeat ($urandom_range(1, 400)) @(negedge clk);
      endcase
    end
    send("4");
    repeat (6) @(negedge clk);
    check("end_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
